// File: rtl/count_checker_pkg.sv
// Shared encodings for count_checker: FSM states, readout selects, status layout,
// and the saturating-count step used by both the counters and the readout preview.
package count_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACQ    = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  localparam logic [1:0] SEL_LAST   = 2'd0;
  localparam logic [1:0] SEL_ERR    = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_WRAP   = 2'd3;

  localparam int STAT_PULSE_BIT  = 0;
  localparam int STAT_LOCKED_BIT = 1;
  localparam int STAT_RUN_LSB    = 2;
  localparam int STAT_STATE_LSB  = 6;
  localparam int STAT_BITS       = 8;

  function automatic logic [STAT_BITS-1:0] pack_status(
    input state_t     st,
    input logic [3:0] run,
    input logic       lk,
    input logic       ep
  );
    logic [STAT_BITS-1:0] s;
    s = '0;
    s[STAT_PULSE_BIT]       = ep;
    s[STAT_LOCKED_BIT]      = lk;
    s[STAT_RUN_LSB +: 4]    = run;
    s[STAT_STATE_LSB +: 2]  = st;
    return s;
  endfunction

  // Clear beats increment; increment stops at max instead of wrapping.
  function automatic logic [31:0] sat_next(
    input logic [31:0] q,
    input logic [31:0] max,
    input logic        inc,
    input logic        clr
  );
    logic [31:0] r;
    r = q;
    if (clr) begin
      r = '0;
    end else if (inc && (q < max)) begin
      r = q + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter with synchronous clear; used for the error and wrap tallies.
module sat_counter
  import count_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  assign q_next = WIDTH'(sat_next(32'(q_reg), 32'(CNT_MAX), inc, clr));
  assign q      = q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

endmodule

// File: rtl/count_checker.sv
// Checks that an external count bus advances by +1 per enabled sample, tracks lock,
// tallies errors/wraps and muxes results to rd_data. Option: COUNT_CHECKER_WRAP_EN.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             locked,
  output logic             err_pulse
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CNT);

  state_t           state_reg, state_next;
  logic [3:0]       run_reg, run_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic             err_pulse_reg, err_pulse_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;

  logic [WIDTH-1:0] prev_inc;
  logic [3:0]       run_inc;
  logic             match;
  logic             err_evt;
  logic [WIDTH-1:0] err_cnt, err_cnt_post;
  logic [WIDTH-1:0] wrap_cnt_post;
  logic             locked_next;

  assign prev_inc = prev_reg + WIDTH'(1);
  assign run_inc  = run_reg + 4'd1;
  assign match    = (count_in == prev_inc);

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    prev_next  = prev_reg;
    err_evt    = 1'b0;
    if (en) begin
      prev_next = count_in;
      case (state_reg)
        // The first sample only seeds prev; there is nothing to compare it against.
        ST_IDLE: begin
          state_next = ST_ACQ;
          run_next   = 4'd0;
        end
        ST_ACQ: begin
          if (!match) begin
            run_next = 4'd0;
          end else if (run_inc == LOCK_RUN) begin
            state_next = ST_LOCKED;
            run_next   = LOCK_RUN;
          end else begin
            run_next = run_inc;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            err_evt    = 1'b1;
            state_next = ST_ACQ;
            run_next   = 4'd0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          run_next   = 4'd0;
        end
      endcase
    end
  end

  assign err_pulse_next = err_evt;
  assign locked_next    = (state_next == ST_LOCKED);

  sat_counter #(.WIDTH(WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_evt),
    .clr   (clr),
    .q     (err_cnt)
  );

  // Readout shows the value each counter holds after this edge.
  assign err_cnt_post = WIDTH'(sat_next(32'(err_cnt), 32'(CNT_MAX), err_evt, clr));

`ifdef COUNT_CHECKER_WRAP_EN
  logic             wrap_evt;
  logic [WIDTH-1:0] wrap_cnt;

  assign wrap_evt = en && (state_reg == ST_LOCKED) && match && (prev_reg == CNT_MAX);

  sat_counter #(.WIDTH(WIDTH)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wrap_evt),
    .clr   (clr),
    .q     (wrap_cnt)
  );

  assign wrap_cnt_post = WIDTH'(sat_next(32'(wrap_cnt), 32'(CNT_MAX), wrap_evt, clr));
`else
  assign wrap_cnt_post = '0;
`endif

  always_comb begin
    rd_data_next = '0;
    case (sel)
      SEL_LAST:   rd_data_next = prev_next;
      SEL_ERR:    rd_data_next = err_cnt_post;
      SEL_STATUS: rd_data_next = WIDTH'(pack_status(state_next, run_next, locked_next,
                                                    err_pulse_next));
      SEL_WRAP:   rd_data_next = wrap_cnt_post;
      default:    rd_data_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      run_reg       <= 4'd0;
      prev_reg      <= '0;
      err_pulse_reg <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= run_next;
      prev_reg      <= prev_next;
      err_pulse_reg <= err_pulse_next;
      rd_data_reg   <= rd_data_next;
    end
  end

  assign locked    = (state_reg == ST_LOCKED);
  assign err_pulse = err_pulse_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them one cycle after each driven vector.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] count_in;
  logic       clr;
  logic [1:0] sel;
  logic [7:0] rd_data;
  logic       locked;
  logic       err_pulse;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(8), .LOCK_CNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .count_in  (count_in),
    .clr       (clr),
    .sel       (sel),
    .rd_data   (rd_data),
    .locked    (locked),
    .err_pulse (err_pulse)
  );

`ifdef COUNT_CHECKER_WRAP_EN
  localparam int EXP_WRAP = 1;
`else
  localparam int EXP_WRAP = 0;
`endif

  // -1 in any expected field means "don't compare".
  typedef struct {
    int    cyc;
    int    rd;
    int    lk;
    int    ep;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_total++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      if (e.cyc < cyc_cnt) begin
        chk(e.name, "stale", cyc_cnt, e.cyc);
      end else begin
        if (e.rd >= 0) chk(e.name, "rd_data", int'(rd_data), e.rd);
        if (e.lk >= 0) chk(e.name, "locked", int'(locked), e.lk);
        if (e.ep >= 0) chk(e.name, "err_pulse", int'(err_pulse), e.ep);
        $display("txn %-14s cyc=%0d rd=0x%02h locked=%0b err_pulse=%0b",
                 e.name, cyc_cnt, rd_data, locked, err_pulse);
      end
    end
  end

  task automatic push(input int erd, input int elk, input int eep, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.rd   = erd;
    e.lk   = elk;
    e.ep   = eep;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input bit e, input int c, input bit cl, input int s,
                      input int erd, input int elk, input int eep, input string nm);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    en       = e;
    count_in = c[7:0];
    clr      = cl;
    sel      = s[1:0];
    push(erd, elk, eep, nm);
  endtask

  task automatic do_reset(input int s, input string nm);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    en       = 1'b1;
    count_in = 8'h55;
    clr      = 1'b1;
    sel      = s[1:0];
    push(0, 0, 0, nm);
  endtask

  initial begin
    int s;
    int erd;
    rst_n    = 1'b0;
    en       = 1'b0;
    count_in = 8'h00;
    clr      = 1'b0;
    sel      = 2'd0;

    // 1: acquire and lock on 0..4
    do_reset(0, "t1_reset");
    step(1, 0, 0, 0, 0, 0, 0, "t1_s0");
    for (int v = 1; v <= 3; v++) step(1, v, 0, 0, v, 0, 0, "t1_acq");
    step(1, 4, 0, 2, 'h92, 1, 0, "t1_lock_stat");
    step(0, 0, 0, 1, 0, 1, 0, "t1_err0");

    // 2: one mismatch while locked, second mismatch in ACQ is not an error, relock
    step(1, 10, 0, 0, 10, 0, 1, "t2_err");
    step(1, 12, 0, 1, 1, 0, 0, "t2_acq_miss");
    for (int v = 13; v <= 15; v++) step(1, v, 0, 0, v, 0, 0, "t2_reacq");
    step(1, 16, 0, 0, 16, 1, 0, "t2_relock");

    // 3: lock just below the top and wrap through zero
    step(1, 250, 0, 0, 250, 0, 1, "t3_err");
    for (int v = 251; v <= 253; v++) step(1, v, 0, 0, v, 0, 0, "t3_acq");
    step(1, 254, 0, 0, 254, 1, 0, "t3_lock");
    step(1, 255, 0, 0, 255, 1, 0, "t3_255");
    step(1, 0, 0, 0, 0, 1, 0, "t3_wrap0");
    step(1, 1, 0, 3, EXP_WRAP, 1, 0, "t3_wrap_cnt");
    step(0, 0, 0, 1, 2, 1, 0, "t3_err2");

    // 4: 300 lock/mismatch rounds saturate err_cnt, then clr beats a same-edge error
    for (int i = 0; i < 300; i++) begin
      step(1, 100, 0, 0, 100, 0, 1, "t4_err");
      for (int v = 101; v <= 103; v++) step(1, v, 0, 0, -1, 0, 0, "t4_acq");
      step(1, 104, 0, 0, 104, 1, 0, "t4_lock");
    end
    step(0, 0, 0, 1, 255, 1, 0, "t4_sat");
    step(1, 100, 1, 1, 0, 0, 1, "t4_clr_err");
    step(0, 0, 0, 1, 0, 0, 0, "t4_after_clr");

    // 5: relock, then en=0 with junk input must freeze everything
    for (int v = 101; v <= 103; v++) step(1, v, 0, 0, v, 0, 0, "t5_acq");
    step(1, 104, 0, 0, 104, 1, 0, "t5_lock");
    for (int i = 0; i < 20; i++) begin
      s   = $urandom_range(0, 2);
      erd = (s == 0) ? 104 : ((s == 1) ? 0 : 'h92);
      step(0, $urandom_range(0, 255), 0, s, erd, 1, 0, "t5_hold");
    end
    step(1, 105, 0, 0, 105, 1, 0, "t5_keep");

    // 6: three errors, then a one-cycle reset wipes everything
    for (int r = 0; r < 3; r++) begin
      step(1, 200, 0, 0, 200, 0, 1, "t6_err");
      for (int v = 201; v <= 203; v++) step(1, v, 0, 0, v, 0, 0, "t6_acq");
      step(1, 204, 0, 0, 204, 1, 0, "t6_lock");
    end
    step(0, 0, 0, 1, 3, 1, 0, "t6_err3");
    do_reset(1, "t6_reset");
    step(0, 0, 0, 2, 0, 0, 0, "t6_idle_stat");
    step(0, 0, 0, 1, 0, 0, 0, "t6_err_zero");
    step(0, 0, 0, 3, 0, 0, 0, "t6_wrap_zero");
    step(1, 77, 0, 2, 'h40, 0, 0, "t6_first");
    step(1, 99, 0, 0, 99, 0, 0, "t6_acq_miss");

    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) chk("drain", "pending", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
